// File: rtl/bcd_counter_multi_pkg.sv
// Shared constants and the load-saturation helper for the multi-digit BCD counter.
package bcd_counter_multi_pkg;

  localparam int         DIGIT_W  = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // Clamp a nibble to a legal BCD digit so no non-decimal state can be loaded.
  function automatic logic [3:0] bcd_sat(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_counter_multi_digit.sv
// One decimal digit of the counter: a 4-bit register with load and a
// carry/borrow ripple stage for up/down stepping.
module bcd_counter_multi_digit
  import bcd_counter_multi_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [3:0]   ld_digit,
  input  logic         step,
  input  logic         up_dn,
  input  logic         cin,
  output logic [3:0]   digit,
  output logic         cout
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  // Next digit value and ripple carry/borrow out; load overrides stepping.
  always_comb begin
    digit_d = digit_q;
    cout    = 1'b0;
    if (load) begin
      digit_d = ld_digit;
    end else if (step && cin) begin
      if (up_dn) begin
        if (digit_q == BCD_MAX) begin
          digit_d = BCD_ZERO;
          cout    = 1'b1;
        end else begin
          digit_d = digit_q + 4'd1;
        end
      end else begin
        if (digit_q == BCD_ZERO) begin
          digit_d = BCD_MAX;
          cout    = 1'b1;
        end else begin
          digit_d = digit_q - 4'd1;
        end
      end
    end else begin
      digit_d = digit_q;
    end
  end

  // Digit register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      digit_q <= BCD_ZERO;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;

endmodule

// File: rtl/bcd_counter_multi.sv
// Multi-digit up/down BCD counter with parallel load and a clock-enable
// prescaler; everything runs on clk, outputs are all registered.
module bcd_counter_multi
  import bcd_counter_multi_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        up_dn,
  input  logic                        load,
  input  logic [DIGIT_W*DIGITS-1:0]   load_val,
  output logic [DIGIT_W*DIGITS-1:0]   count,
  output logic                        carry,
  output logic                        tick
);

  localparam int            PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          carry_q;
  logic          carry_d;
  logic          tick_q;
  logic          tick_d;
  logic          step_s;
  logic [DIGITS:0] chain_s;

  assign step_s     = en && (presc_q == PRESC_LAST);
  assign chain_s[0] = 1'b1;

  // Digit slices ripple carry/borrow from LS to MS digit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_counter_multi_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .ld_digit (bcd_sat(load_val[DIGIT_W*g +: DIGIT_W])),
      .step     (step_s),
      .up_dn    (up_dn),
      .cin      (chain_s[g]),
      .digit    (count[DIGIT_W*g +: DIGIT_W]),
      .cout     (chain_s[g+1])
    );
  end

  // Prescaler advance and the pulse outputs; load suppresses both pulses.
  always_comb begin
    presc_d = presc_q;
    carry_d = 1'b0;
    tick_d  = 1'b0;
    if (load) begin
      presc_d = '0;
    end else if (step_s) begin
      presc_d = '0;
      tick_d  = 1'b1;
      carry_d = chain_s[DIGITS];
    end else if (en) begin
      presc_d = presc_q + PW'(1);
    end else begin
      presc_d = presc_q;
    end
  end

  // Prescaler and pulse registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q <= '0;
      carry_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      carry_q <= carry_d;
      tick_q  <= tick_d;
    end
  end

  assign carry = carry_q;
  assign tick  = tick_q;

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Scoreboard bench: three counters (2-digit/DIV1, 2-digit/DIV5, 4-digit/DIV1)
// share stimulus; a decimal-arithmetic model predicts every cycle.
module tb_bcd_counter_multi;

  typedef struct {
    logic [15:0] cnt;
    logic        c;
    logic        t;
    int          presc;
  } mdl_t;

  typedef struct {
    mdl_t a;
    mdl_t p;
    mdl_t w;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        up_dn = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic [7:0]  a_count;
  logic [7:0]  p_count;
  logic [15:0] w_count;
  logic        a_carry, a_tick, p_carry, p_tick, w_carry, w_tick;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  mdl_t ma, mp, mw;

  always #5 clk = ~clk;

  bcd_counter_multi #(.DIGITS(2), .DIV(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val[7:0]), .count(a_count), .carry(a_carry), .tick(a_tick));

  bcd_counter_multi #(.DIGITS(2), .DIV(5)) u_p (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val[7:0]), .count(p_count), .carry(p_carry), .tick(p_tick));

  bcd_counter_multi #(.DIGITS(4), .DIV(1)) u_w (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(w_count), .carry(w_carry), .tick(w_tick));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v, input int nd);
    int r = 0;
    int m = 1;
    for (int i = 0; i < nd; i++) begin
      logic [3:0] d = v[4*i +: 4];
      if (d > 4'd9) d = 4'd9;
      r += int'(d) * m;
      m *= 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int x, input int nd);
    logic [15:0] r = 16'h0000;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x /= 10;
    end
    return r;
  endfunction

  // Reference behaviour computed with plain decimal arithmetic.
  function automatic mdl_t mdl_next(input mdl_t m, input int nd, input int div, input logic r,
                                    input logic e, input logic u, input logic l, input logic [15:0] lv);
    mdl_t n = m;
    int   v;
    int   md = 1;
    for (int i = 0; i < nd; i++) md *= 10;
    n.c = 1'b0;
    n.t = 1'b0;
    if (!r) begin
      n.cnt = 16'h0000;
      n.presc = 0;
    end else if (l) begin
      n.cnt = int2bcd(bcd2int(lv, nd), nd);
      n.presc = 0;
    end else if (e) begin
      if (m.presc == div - 1) begin
        n.presc = 0;
        n.t = 1'b1;
        v = bcd2int(m.cnt, nd);
        if (u) begin
          if (v == md - 1) begin v = 0; n.c = 1'b1; end else v = v + 1;
        end else begin
          if (v == 0) begin v = md - 1; n.c = 1'b1; end else v = v - 1;
        end
        n.cnt = int2bcd(v, nd);
      end else begin
        n.presc = m.presc + 1;
      end
    end
    return n;
  endfunction

  task automatic cycle(input logic r, input logic e, input logic u, input logic l, input logic [15:0] lv);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; up_dn = u; load = l; load_val = lv;
    ma = mdl_next(ma, 2, 1, r, e, u, l, lv);
    mp = mdl_next(mp, 2, 5, r, e, u, l, lv);
    mw = mdl_next(mw, 4, 1, r, e, u, l, lv);
    x.a = ma; x.p = mp; x.w = mw;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check_val("a_count", {24'h0, a_count}, {16'h0, x.a.cnt});
    check_val("a_carry", {31'h0, a_carry}, {31'h0, x.a.c});
    check_val("a_tick",  {31'h0, a_tick},  {31'h0, x.a.t});
    check_val("p_count", {24'h0, p_count}, {16'h0, x.p.cnt});
    check_val("p_carry", {31'h0, p_carry}, {31'h0, x.p.c});
    check_val("p_tick",  {31'h0, p_tick},  {31'h0, x.p.t});
    check_val("w_count", {16'h0, w_count}, {16'h0, x.w.cnt});
    check_val("w_carry", {31'h0, w_carry}, {31'h0, x.w.c});
    check_val("w_tick",  {31'h0, w_tick},  {31'h0, x.w.t});
  endtask

  initial begin
    int ncar;
    ma = '{16'h0000, 1'b0, 1'b0, 0};
    mp = ma;
    mw = ma;

    // Reset mid-count, held with load and en asserted.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'h0045);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    check_val("pre_rst_47", {24'h0, a_count}, 32'h0000_0047);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'h0077);
    check_val("rst_cnt", {24'h0, a_count}, 32'h0000_0000);
    check_val("rst_tick", {31'h0, a_tick}, 32'h0000_0000);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'h0077);
    check_val("rst_hold", {16'h0, w_count}, 32'h0000_0000);

    // Up wrap on both widths.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h9998);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    check_val("up_99", {24'h0, a_count}, 32'h0000_0099);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    check_val("up_wrap", {23'h0, a_carry, a_count}, 32'h0000_0100);
    check_val("w_up_wrap", {15'h0, w_carry, w_count}, 32'h0001_0000);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    check_val("carry_1cyc", {31'h0, a_carry}, 32'h0000_0000);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h0009);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    check_val("up_09_10", {23'h0, a_carry, a_count}, 32'h0000_0010);

    // Down wrap.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'h0001);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_val("dn_00", {23'h0, a_carry, a_count}, 32'h0000_0000);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_val("dn_wrap", {23'h0, a_carry, a_count}, 32'h0000_0199);
    check_val("w_dn_wrap", {15'h0, w_carry, w_count}, 32'h0001_9999);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'h0010);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_val("dn_10_09", {24'h0, a_count}, 32'h0000_0009);

    // Prescaler: ticks on enabled cycles 5, 10, 15; an en gap delays the next.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    for (int i = 1; i <= 15; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
      check_val("presc_tick", {31'h0, p_tick}, (i % 5 == 0) ? 32'd1 : 32'd0);
    end
    check_val("presc_cnt", {24'h0, p_count}, 32'h0000_0003);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
      check_val("presc_gap", {31'h0, p_tick}, (i == 5) ? 32'd1 : 32'd0);
    end

    // Load saturation, load beating a wrapping step, prescaler restart.
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'h00F3);
    check_val("load_sat", {24'h0, a_count}, 32'h0000_0093);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'hFF99);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h0042);
    check_val("load_pri", {23'h0, a_carry, a_count}, 32'h0000_0042);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h0050);
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
      check_val("load_presc", {31'h0, p_tick}, (i == 5) ? 32'd1 : 32'd0);
    end

    // Random en/up_dn/load mix.
    for (int i = 0; i < 200; i++) begin
      logic [15:0] rv;
      rv = 16'($urandom);
      cycle(1'b1, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0), rv);
    end

    // Full 4-digit revolution: exactly one carry.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    ncar = 0;
    for (int i = 0; i < 10000; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
      if (w_carry) ncar++;
    end
    check_val("rev_carries", 32'(ncar), 32'd1);
    check_val("rev_count", {16'h0, w_count}, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
